// File: rtl/an_encoder_inj.sv
// AN-code encoder with optional single arithmetic error injection.
// Takes a data word N and forms A*N with a shift-and-add multiplier, one
// partial product per bit of A. It can then add or subtract 2^k, so the
// downstream decoder receives exactly the corrupted word it must correct.
module an_encoder_inj #(
    parameter int N_W  = 23,
    parameter int A    = 29,
    parameter int A_W  = 5,
    parameter int AN_W = 28,
    parameter int IB_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_W-1:0]  in_n,
    input  logic            inj_en,
    input  logic            inj_sub,
    input  logic [IB_W-1:0] inj_bit,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AN_W-1:0] out_an,
    output logic            out_inj
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        INJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int                CNT_W    = (A_W > 1) ? $clog2(A_W) : 1;
    localparam logic [A_W-1:0]    A_VEC    = A_W'(A);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(A_W - 1);

    state_t            state_q,     state_d;
    logic [N_W-1:0]    n_q,         n_d;
    logic              inj_en_q,    inj_en_d;
    logic              inj_sub_q,   inj_sub_d;
    logic [IB_W-1:0]   inj_bit_q,   inj_bit_d;
    logic [AN_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [AN_W-1:0]   out_an_q,    out_an_d;
    logic              out_inj_q,   out_inj_d;
    logic              out_valid_q, out_valid_d;

    // Partial product for the current multiplier bit and the injected error term.
    logic [AN_W-1:0]   partial;
    logic [AN_W-1:0]   err_term;
    logic              inj_hit;

    assign partial  = AN_W'(n_q) << cnt_q;
    assign err_term = AN_W'(1) << inj_bit_q;
    // An out-of-range bit index yields an uncorrupted word.
    assign inj_hit  = inj_en_q && ({{(32-IB_W){1'b0}}, inj_bit_q} < 32'(AN_W));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_an    = out_an_q;
    assign out_inj   = out_inj_q;

    // State and datapath registers; an asynchronous reset discards any word in flight.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            inj_en_q    <= 1'b0;
            inj_sub_q   <= 1'b0;
            inj_bit_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_an_q    <= '0;
            out_inj_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            inj_en_q    <= inj_en_d;
            inj_sub_q   <= inj_sub_d;
            inj_bit_q   <= inj_bit_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_an_q    <= out_an_d;
            out_inj_q   <= out_inj_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic: capture, iterate over A's bits, apply the error, hand off.
    // NOTE: every _d gets a hold default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        inj_en_d    = inj_en_q;
        inj_sub_d   = inj_sub_q;
        inj_bit_d   = inj_bit_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_an_d    = out_an_q;
        out_inj_d   = out_inj_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d       = in_n;
                    inj_en_d  = inj_en;
                    inj_sub_d = inj_sub;
                    inj_bit_d = inj_bit;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (A_VEC[cnt_q]) begin
                    acc_d = acc_q + partial;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = INJ;
                end
            end
            INJ: begin
                if (inj_hit) begin
                    out_an_d  = inj_sub_q ? (acc_q - err_term) : (acc_q + err_term);
                    out_inj_d = 1'b1;
                end else begin
                    out_an_d  = acc_q;
                    out_inj_d = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
